// File: rtl/reg_share_pkg.sv
// Shared definitions for the shared-register arbiter and its picker.
package reg_share_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_HOLD  = 2;

    // Bits needed to index n items; never less than one so ports stay legal.
    function automatic int clog2w(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            any
);

    // Walk offsets from farthest to nearest so the nearest hit is the one kept.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                winner = IW'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin owner of one shared WIDTH-bit register: grant, load once, hold, release.
module reg_share_arb
    import reg_share_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREQ  = DEF_NREQ,
    parameter  int HOLD  = DEF_HOLD,
    localparam int IW    = clog2w(NREQ),
    localparam int CW    = clog2w(HOLD)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [IW-1:0]         owner,
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic [NREQ-1:0]       done
);

    state_e           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q,   ptr_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] q_q,     q_d;

    logic [IW-1:0]    win;
    logic             win_any;
    logic [WIDTH-1:0] wsel;
    logic [NREQ-1:0]  owner_oh;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (win),
        .any    (win_any)
    );

    assign wsel     = wdata[owner_q*WIDTH +: WIDTH];
    assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

    // State, owner, pointer, hold counter and the shared register; reset wipes all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    // Next state: arbitrate in IDLE, load on the first GRANT edge, advance ptr on RELEASE.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = GRANT;
                    owner_d = win;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (cnt_q == '0) q_d = wsel;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(HOLD - 1)) state_d = RELEASE;
            end
            RELEASE: begin
                state_d = IDLE;
                ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        gnt  = '0;
        done = '0;
        busy = (state_q != IDLE);
        if (state_q == GRANT)   gnt  = owner_oh;
        if (state_q == RELEASE) done = owner_oh;
    end

    assign owner = owner_q;
    assign q     = q_q;

endmodule

// File: tb/tb_reg_share_arb.sv
// Directed bench for reg_share_arb at WIDTH=8, NREQ=4, HOLD=2.
module tb_reg_share_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  q;
    logic        busy;
    logic [3:0]  done;

    int errors = 0;
    int checks = 0;

    reg_share_arb #(.WIDTH(8), .NREQ(4), .HOLD(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .owner (owner),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_gnt"},  32'(gnt),  32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    logic [3:0] oh;
    logic [7:0] dv;

    initial begin
        rst   = 1'b0;
        req   = 4'b0000;
        wdata = 32'h0;
        tick();
        tick();
        chk("rst_gnt",   32'(gnt),   32'h0);
        chk("rst_q",     32'(q),     32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_done",  32'(done),  32'h0);
        rst = 1'b1;
        tick();
        idle_chk("post_rst");

        // Reset in the middle of a grant
        req = 4'b0001;
        wdata[7:0] = 8'hA5;
        tick();
        chk("mg_e0_gnt",  32'(gnt),  32'h1);
        chk("mg_e0_busy", 32'(busy), 32'h1);
        chk("mg_e0_q",    32'(q),    32'h0);
        tick();
        chk("mg_e1_gnt", 32'(gnt), 32'h1);
        chk("mg_e1_q",   32'(q),   32'hA5);
        rst = 1'b0;
        #1;
        chk("mg_arst_gnt",  32'(gnt),  32'h0);
        chk("mg_arst_q",    32'(q),    32'h0);
        chk("mg_arst_busy", 32'(busy), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("mg_fresh_gnt", 32'(gnt), 32'h1);
        chk("mg_fresh_q0",  32'(q),   32'h0);
        tick();
        chk("mg_fresh_q1", 32'(q), 32'hA5);
        req = 4'b0000;
        tick();
        chk("mg_rel_done", 32'(done), 32'h1);
        chk("mg_rel_gnt",  32'(gnt),  32'h0);
        chk("mg_rel_busy", 32'(busy), 32'h1);
        tick();
        idle_chk("mg_idle");

        // Single request, ptr=1
        req = 4'b0100;
        wdata[23:16] = 8'h3C;
        tick();
        chk("sg_e0_gnt",   32'(gnt),   32'h4);
        chk("sg_e0_owner", 32'(owner), 32'h2);
        chk("sg_e0_busy",  32'(busy),  32'h1);
        tick();
        chk("sg_e1_gnt",  32'(gnt),  32'h4);
        chk("sg_e1_q",    32'(q),    32'h3C);
        chk("sg_e1_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        chk("sg_rel_gnt",  32'(gnt),  32'h0);
        chk("sg_rel_done", 32'(done), 32'h4);
        chk("sg_rel_busy", 32'(busy), 32'h1);
        tick();
        idle_chk("sg_idle");
        chk("sg_idle_q",     32'(q),     32'h3C);
        chk("sg_idle_owner", 32'(owner), 32'h2);

        // All requesting from reset: order 0,1,2,3,0 with 4-cycle spacing
        rst = 1'b0;
        #1;
        tick();
        rst   = 1'b1;
        wdata = 32'hD3D2D1D0;
        req   = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            oh = 4'b0001 << (n % 4);
            dv = 8'hD0 + 8'(n % 4);
            tick();
            chk("all_e0_gnt",   32'(gnt),   32'(oh));
            chk("all_e0_owner", 32'(owner), 32'(n % 4));
            tick();
            chk("all_e1_gnt", 32'(gnt), 32'(oh));
            chk("all_e1_q",   32'(q),   32'(dv));
            tick();
            chk("all_rel_done", 32'(done), 32'(oh));
            chk("all_rel_gnt",  32'(gnt),  32'h0);
            tick();
            idle_chk("all_idle");
        end
        req = 4'b0000;

        // Wrap and skip: serve 2 to set ptr=3, then 0011 gives 0 then 1
        req = 4'b0100;
        tick();
        chk("wr_pre_owner", 32'(owner), 32'h2);
        tick();
        req = 4'b0000;
        tick();
        tick();
        req = 4'b0011;
        tick();
        chk("wr_a_gnt", 32'(gnt), 32'h1);
        tick();
        tick();
        chk("wr_a_done", 32'(done), 32'h1);
        tick();
        idle_chk("wr_a_idle");
        tick();
        chk("wr_b_gnt", 32'(gnt), 32'h2);
        tick();
        req = 4'b0000;
        tick();
        chk("wr_b_done", 32'(done), 32'h2);
        tick();

        // Early drop of req[3] after E0
        req = 4'b1000;
        wdata[31:24] = 8'h5A;
        tick();
        chk("ed_e0_gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        tick();
        chk("ed_e1_gnt", 32'(gnt), 32'h8);
        chk("ed_e1_q",   32'(q),   32'h5A);
        tick();
        chk("ed_rel_done", 32'(done), 32'h8);
        chk("ed_rel_gnt",  32'(gnt),  32'h0);
        tick();
        idle_chk("ed_idle");

        // wdata1 changes after the load; q holds until a fresh grant
        req = 4'b0010;
        wdata[15:8] = 8'h11;
        tick();
        chk("wc_e0_gnt", 32'(gnt), 32'h2);
        tick();
        chk("wc_e1_q", 32'(q), 32'h11);
        wdata[15:8] = 8'h22;
        req = 4'b0000;
        tick();
        chk("wc_rel_q",    32'(q),    32'h11);
        chk("wc_rel_done", 32'(done), 32'h2);
        tick();
        chk("wc_idle_q", 32'(q), 32'h11);
        tick();
        chk("wc_idle2_q", 32'(q), 32'h11);
        req = 4'b0010;
        tick();
        chk("wc_new_e0_q", 32'(q), 32'h11);
        tick();
        chk("wc_new_e1_q", 32'(q), 32'h22);
        req = 4'b0000;
        tick();
        tick();
        idle_chk("end_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
